// File: rtl/mvu_vvu_stream_pkg.sv
// MVU/VVU stream compute: shared widths and arithmetic helpers.
// Helpers cover byte alignment, sign extension and clamped addition.
package mvu_vvu_stream_pkg;

  localparam int FIFO_DEPTH = 2;

  function automatic int byte_align(
    input int w
  );
    return ((w + 7) / 8) * 8;
  endfunction

  function automatic logic signed [63:0] sext(
    input logic [63:0] v,
    input int          w
  );
    logic [63:0] sh;
    sh = v << (64 - w);
    return $signed(sh) >>> (64 - w);
  endfunction

  function automatic logic signed [63:0] sat_add(
    input logic signed [63:0] a,
    input logic signed [63:0] b,
    input int                 w
  );
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi) return hi;
    else if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/mvu_vvu_stream_replay.sv
// Fold counters plus activation replay store.
// Pass 0 records each beat; later passes read it back.
module mvu_vvu_stream_replay
  import mvu_vvu_stream_pkg::*;
#(
  parameter int SF = 2,
  parameter int NF = 2,
  parameter int W  = 8
) (
  input  logic         clk2x,
  input  logic         rst_n,
  input  logic         fire,
  input  logic [W-1:0] act_in,
  output logic [W-1:0] act_out,
  output logic         sf_first,
  output logic         sf_last,
  output logic         nf_first
);

  localparam int SFW = (SF > 1) ? $clog2(SF) : 1;
  localparam int NFW = (NF > 1) ? $clog2(NF) : 1;

  logic [SFW-1:0] sf;
  logic [NFW-1:0] nf;
  logic           nf_last;

  assign sf_first = (sf == '0);
  assign sf_last  = (sf == SFW'(SF - 1));
  assign nf_first = (nf == '0);
  assign nf_last  = (nf == NFW'(NF - 1));

  always_ff @(posedge clk2x or negedge rst_n) begin
    if (!rst_n) begin
      sf <= '0;
      nf <= '0;
    end else if (fire) begin
      if (sf_last) begin
        sf <= '0;
        nf <= nf_last ? '0 : nf + NFW'(1);
      end else begin
        sf <= sf + SFW'(1);
      end
    end
  end

  if (NF > 1) begin : g_store
    logic [W-1:0] mem [SF];

    always_ff @(posedge clk2x or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SF; i++) mem[i] <= '0;
      end else if (fire && nf_first) begin
        mem[sf] <= act_in;
      end
    end

    assign act_out = nf_first ? act_in : mem[sf];
  end else begin : g_pass
    assign act_out = act_in;
  end

endmodule

// File: rtl/mvu_vvu_stream_axi.sv
// MVU/VVU AXI-Stream dot/accumulate with 2-entry credited output FIFO.
// Define MVU_VVU_STREAM_SAT_EN for saturating accumulation.
module mvu_vvu_stream_axi
  import mvu_vvu_stream_pkg::*;
#(
  parameter int IS_MVU             = 1,
  parameter int MW                 = 4,
  parameter int MH                 = 4,
  parameter int PE                 = 2,
  parameter int SIMD               = 2,
  parameter int ACTIVATION_WIDTH   = 4,
  parameter int WEIGHT_WIDTH       = 4,
  parameter int ACCU_WIDTH         = 16,
  parameter int SIGNED_ACTIVATIONS = 0
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic [byte_align(PE*SIMD*WEIGHT_WIDTH)-1:0]
               s_axis_weights_tdata,
  input  logic s_axis_weights_tvalid,
  output logic s_axis_weights_tready,
  input  logic [byte_align(((IS_MVU != 0) ? 1 : PE)
                 *SIMD*ACTIVATION_WIDTH)-1:0]
               s_axis_input_tdata,
  input  logic s_axis_input_tvalid,
  output logic s_axis_input_tready,
  output logic [byte_align(PE*ACCU_WIDTH)-1:0]
               m_axis_output_tdata,
  output logic m_axis_output_tvalid,
  input  logic m_axis_output_tready
);

  localparam int SF  = MW / SIMD;
  localparam int NF  = (IS_MVU != 0) ? MH / PE : 1;
  localparam int AL  = (IS_MVU != 0) ? 1 : PE;
  localparam int IW  = AL * SIMD * ACTIVATION_WIDTH;
  localparam int WW  = PE * SIMD * WEIGHT_WIDTH;
  localparam int OW  = PE * ACCU_WIDTH;
  localparam int OBA = byte_align(OW);
  localparam int PW  = WEIGHT_WIDTH + ACTIVATION_WIDTH + 1;
  localparam int DW  = PW + $clog2(SIMD) + 1;

  function automatic int aidx(input int p, input int s);
    return (IS_MVU != 0) ? s : s * PE + p;
  endfunction

  logic          run;
  logic          fire;
  logic          push;
  logic          pop;
  logic          credit;
  logic          act_ok;
  logic          sf_first;
  logic          sf_last;
  logic          nf_first;
  logic [IW-1:0] act;
  logic [WW-1:0] wdat;
  logic [OW-1:0] res;

  logic [1:0]    cnt;
  logic          rd_ptr;
  logic          wr_ptr;
  logic [OW-1:0] mem [FIFO_DEPTH];

  assign wdat = s_axis_weights_tdata[WW-1:0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) run <= 1'b0;
    else           run <= 1'b1;
  end

  // a full FIFO only blocks the beat that would push into it
  assign credit = !sf_last
                | (cnt != 2'(FIFO_DEPTH))
                | m_axis_output_tready;
  assign act_ok = nf_first ? s_axis_input_tvalid : 1'b1;

  assign s_axis_input_tready   = run & nf_first
                               & s_axis_weights_tvalid
                               & credit;
  assign s_axis_weights_tready = run & act_ok & credit;

  assign fire = s_axis_weights_tvalid & s_axis_weights_tready;
  assign push = fire & sf_last;
  assign pop  = m_axis_output_tvalid & m_axis_output_tready;

  mvu_vvu_stream_replay #(
    .SF (SF),
    .NF (NF),
    .W  (IW)
  ) u_replay (
    .clk2x    (ap_clk),
    .rst_n    (ap_rst_n),
    .fire     (fire),
    .act_in   (s_axis_input_tdata[IW-1:0]),
    .act_out  (act),
    .sf_first (sf_first),
    .sf_last  (sf_last),
    .nf_first (nf_first)
  );

  for (genvar p = 0; p < PE; p++) begin : g_lane
    logic signed [WEIGHT_WIDTH-1:0]   w_e;
    logic        [ACTIVATION_WIDTH-1:0] a_r;
    logic signed [ACTIVATION_WIDTH:0] a_e;
    logic signed [PW-1:0]             prod;
    logic signed [DW-1:0]             dot;
    logic signed [ACCU_WIDTH-1:0]     base;
    logic signed [ACCU_WIDTH-1:0]     nxt;
    logic signed [ACCU_WIDTH-1:0]     acc;

    always_comb begin
      w_e  = '0;
      a_r  = '0;
      a_e  = '0;
      prod = '0;
      dot  = '0;
      for (int s = 0; s < SIMD; s++) begin
        w_e  = $signed(wdat[(p*SIMD+s)*WEIGHT_WIDTH
                            +: WEIGHT_WIDTH]);
        a_r  = act[aidx(p, s)*ACTIVATION_WIDTH
                   +: ACTIVATION_WIDTH];
        a_e  = (SIGNED_ACTIVATIONS != 0)
             ? {a_r[ACTIVATION_WIDTH-1], a_r}
             : {1'b0, a_r};
        prod = w_e * a_e;
        dot  = dot + DW'(prod);
      end
    end

    assign base = sf_first ? '0 : acc;

`ifdef MVU_VVU_STREAM_SAT_EN
    assign nxt = ACCU_WIDTH'(sat_add(64'(base),
                                     64'(dot),
                                     ACCU_WIDTH));
`else
    assign nxt = base + ACCU_WIDTH'(dot);
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)  acc <= '0;
      else if (fire)  acc <= sf_last ? '0 : nxt;
    end

    assign res[p*ACCU_WIDTH +: ACCU_WIDTH] = nxt;
  end

  // at count 2 a push lands in the slot being popped
  assign wr_ptr = rd_ptr ^ cnt[0];

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cnt    <= '0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wr_ptr] <= res;
      if (pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign m_axis_output_tvalid = (cnt != 2'd0);
  assign m_axis_output_tdata  = OBA'(mem[rd_ptr]);

endmodule

// File: tb/tb_mvu_vvu_stream_axi.sv
// Scoreboard bench for mvu_vvu_stream_axi: MVU, VVU and 8-bit accumulator
// instances driven with directed vectors.
module tb_mvu_vvu_stream_axi;

  localparam int LIMIT = 300;

`ifdef MVU_VVU_STREAM_SAT_EN
  localparam logic [15:0] EXP5 = 16'h7F7F;
`else
  localparam logic [15:0] EXP5 = 16'hA4A4;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   i0_hs  = 0;

  logic [15:0] w0_data, w1_data, w2_data;
  logic        w0_valid, w1_valid, w2_valid;
  logic        w0_ready, w1_ready, w2_ready;
  logic [7:0]  i0_data, i2_data;
  logic [15:0] i1_data;
  logic        i0_valid, i1_valid, i2_valid;
  logic        i0_ready, i1_ready, i2_ready;
  logic [31:0] o0_data, o1_data;
  logic [15:0] o2_data;
  logic        o0_valid, o1_valid, o2_valid;
  logic        o0_ready, o1_ready, o2_ready;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [15:0] q2[$];

  mvu_vvu_stream_axi u0 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_weights_tdata(w0_data),
    .s_axis_weights_tvalid(w0_valid),
    .s_axis_weights_tready(w0_ready),
    .s_axis_input_tdata(i0_data),
    .s_axis_input_tvalid(i0_valid),
    .s_axis_input_tready(i0_ready),
    .m_axis_output_tdata(o0_data),
    .m_axis_output_tvalid(o0_valid),
    .m_axis_output_tready(o0_ready)
  );

  mvu_vvu_stream_axi #(.IS_MVU(0), .MH(2)) u1 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_weights_tdata(w1_data),
    .s_axis_weights_tvalid(w1_valid),
    .s_axis_weights_tready(w1_ready),
    .s_axis_input_tdata(i1_data),
    .s_axis_input_tvalid(i1_valid),
    .s_axis_input_tready(i1_ready),
    .m_axis_output_tdata(o1_data),
    .m_axis_output_tvalid(o1_valid),
    .m_axis_output_tready(o1_ready)
  );

  mvu_vvu_stream_axi #(.ACCU_WIDTH(8)) u2 (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .s_axis_weights_tdata(w2_data),
    .s_axis_weights_tvalid(w2_valid),
    .s_axis_weights_tready(w2_ready),
    .s_axis_input_tdata(i2_data),
    .s_axis_input_tvalid(i2_valid),
    .s_axis_input_tready(i2_ready),
    .m_axis_output_tdata(o2_data),
    .m_axis_output_tvalid(o2_valid),
    .m_axis_output_tready(o2_ready)
  );

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic extra(input string nm, input logic [63:0] got);
    checks++;
    errors++;
    $display("FAIL %s: got %0h required no output", nm, got);
  endtask

  // monitors: sample 1 unit after the falling edge, pop on handshake
  always begin
    @(negedge clk);
    #1;
    if (rst_n && o0_valid && o0_ready) begin
      if (q0.size() == 0) extra("u0_extra", 64'(o0_data));
      else chk("u0_out", 64'(o0_data), 64'(q0.pop_front()));
    end
    if (rst_n && o1_valid && o1_ready) begin
      if (q1.size() == 0) extra("u1_extra", 64'(o1_data));
      else chk("u1_out", 64'(o1_data), 64'(q1.pop_front()));
    end
    if (rst_n && o2_valid && o2_ready) begin
      if (q2.size() == 0) extra("u2_extra", 64'(o2_data));
      else chk("u2_out", 64'(o2_data), 64'(q2.pop_front()));
    end
    if (rst_n && i0_valid && i0_ready) i0_hs++;
  end

  task automatic feed_i0(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    i0_data  = d;
    i0_valid = 1'b1;
    forever begin
      #4;
      if (i0_ready || n >= LIMIT) break;
      n++;
      @(negedge clk);
    end
    chk("u0_in_accept", 64'(i0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    i0_valid = 1'b0;
  endtask

  task automatic feed_w0(input logic [15:0] d, output logic ir);
    int n;
    n = 0;
    @(negedge clk);
    w0_data  = d;
    w0_valid = 1'b1;
    forever begin
      #4;
      if (w0_ready || n >= LIMIT) break;
      n++;
      @(negedge clk);
    end
    ir = i0_ready;
    chk("u0_w_accept", 64'(w0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    w0_valid = 1'b0;
  endtask

  task automatic beat_u1(input logic [15:0] w, input logic [15:0] a);
    int n;
    n = 0;
    @(negedge clk);
    w1_data = w; w1_valid = 1'b1;
    i1_data = a; i1_valid = 1'b1;
    forever begin
      #4;
      if (w1_ready || n >= LIMIT) break;
      n++;
      @(negedge clk);
    end
    chk("u1_beat_accept", 64'(w1_ready & i1_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    w1_valid = 1'b0; i1_valid = 1'b0;
  endtask

  task automatic beat_u2(input logic [15:0] w, input logic [7:0] a,
                         input logic av);
    int n;
    n = 0;
    @(negedge clk);
    w2_data = w; w2_valid = 1'b1;
    i2_data = a; i2_valid = av;
    forever begin
      #4;
      if (w2_ready || n >= LIMIT) break;
      n++;
      @(negedge clk);
    end
    chk("u2_beat_accept", 64'(w2_ready), 64'd1);
    chk("u2_in_ready", 64'(i2_ready), 64'(av));
    @(posedge clk);
    @(negedge clk);
    w2_valid = 1'b0; i2_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ir;
    rst_n = 1'b0;
    w0_data = '0; w1_data = '0; w2_data = '0;
    i0_data = '0; i1_data = '0; i2_data = '0;
    w0_valid = 1'b1; w1_valid = 1'b1; w2_valid = 1'b1;
    i0_valid = 1'b1; i1_valid = 1'b1; i2_valid = 1'b1;
    o0_ready = 1'b1; o1_ready = 1'b1; o2_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_u0_w_ready", 64'(w0_ready), 64'd0);
    chk("rst_u0_i_ready", 64'(i0_ready), 64'd0);
    chk("rst_u0_o_valid", 64'(o0_valid), 64'd0);
    chk("rst_u1_w_ready", 64'(w1_ready), 64'd0);
    chk("rst_u1_o_valid", 64'(o1_valid), 64'd0);
    chk("rst_u2_i_ready", 64'(i2_ready), 64'd0);
    chk("rst_u2_o_valid", 64'(o2_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w0_valid = 1'b0; w1_valid = 1'b0; w2_valid = 1'b0;
    i0_valid = 1'b0; i1_valid = 1'b0; i2_valid = 1'b0;
    @(negedge clk);

    // MVU act [1,2,3,4], weights 1; input only taken in pass 0
    q0.push_back(32'h000A_000A);
    q0.push_back(32'h000A_000A);
    i0_hs = 0;
    fork
      begin
        feed_i0(8'h21);
        feed_i0(8'h43);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          feed_w0(16'h1111, ir);
          chk("t2_in_ready_by_pass", 64'(ir), 64'(k < 2));
        end
      end
    join
    drain();
    chk("t2_input_handshakes", 64'(i0_hs), 64'd2);

    // backpressure: two results fill the FIFO, next last beat stalls
    o0_ready = 1'b0;
    q0.push_back(32'h0014_000A);
    q0.push_back(32'h001E_FFF6);
    q0.push_back(32'h001A_001A);
    q0.push_back(32'h0034_001A);
    fork
      begin
        feed_i0(8'h21); feed_i0(8'h43);
        feed_i0(8'h65); feed_i0(8'h87);
      end
      begin
        feed_w0(16'h2211, ir); feed_w0(16'h2211, ir);
        feed_w0(16'h33FF, ir); feed_w0(16'h33FF, ir);
        feed_w0(16'h1111, ir); feed_w0(16'h1111, ir);
        feed_w0(16'h2211, ir); feed_w0(16'h2211, ir);
      end
      begin
        repeat (40) @(negedge clk);
        #4;
        chk("t3_stall_w_ready", 64'(w0_ready), 64'd0);
        chk("t3_stall_i_ready", 64'(i0_ready), 64'd0);
        chk("t3_stall_o_valid", 64'(o0_valid), 64'd1);
        chk("t3_stall_head", 64'(o0_data), 64'h0014_000A);
        @(negedge clk);
        o0_ready = 1'b1;
      end
    join
    drain();

    // VVU de-interleave, second beat zero
    q1.push_back(32'h0006_0004);
    q1.push_back(32'h001C_000C);
    beat_u1(16'h1111, 16'h4321);
    beat_u1(16'h1111, 16'h0000);
    beat_u1(16'h2211, 16'h8765);
    beat_u1(16'h2211, 16'h0000);

    // 8-bit accumulator overflow: wrap or clamp
    q2.push_back(EXP5);
    q2.push_back(EXP5);
    beat_u2(16'h7777, 8'hFF, 1'b1);
    beat_u2(16'h7777, 8'hFF, 1'b1);
    beat_u2(16'h7777, 8'hFF, 1'b0);
    beat_u2(16'h7777, 8'hFF, 1'b0);
    drain();

    // reset mid-vector discards queued result and partial state
    o0_ready = 1'b0;
    fork
      begin
        feed_i0(8'hFF); feed_i0(8'hFF);
      end
      begin
        feed_w0(16'h1111, ir);
        feed_w0(16'h1111, ir);
        feed_w0(16'h1111, ir);
      end
    join
    @(negedge clk);
    #1;
    chk("t6_valid_before_rst", 64'(o0_valid), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    w0_valid = 1'b1; i0_valid = 1'b1;
    #1;
    chk("t6_rst_o_valid", 64'(o0_valid), 64'd0);
    chk("t6_rst_w_ready", 64'(w0_ready), 64'd0);
    chk("t6_rst_i_ready", 64'(i0_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w0_valid = 1'b0; i0_valid = 1'b0;
    o0_ready = 1'b1;
    q0.push_back(32'h000A_000A);
    q0.push_back(32'h000A_000A);
    fork
      begin
        feed_i0(8'h21);
        feed_i0(8'h43);
      end
      begin
        for (int k = 0; k < 4; k++) feed_w0(16'h1111, ir);
      end
    join
    drain();
    repeat (5) @(negedge clk);

    chk("u0_pending", 64'(q0.size()), 64'd0);
    chk("u1_pending", 64'(q1.size()), 64'd0);
    chk("u2_pending", 64'(q2.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
